// File: rtl/frida_spi_config.sv
`default_nettype none
// ============================================================================
// Module      : frida_spi_config
// Description : SPI slave that shifts in a CONFIG_BITS frame, commits it
//               atomically to config_out and streams the old word on spi_sdo.
// Revision    : 1.0
// ============================================================================
module frida_spi_config #(
    parameter int                     CONFIG_BITS = 1280,
    parameter logic [CONFIG_BITS-1:0] RESET_VALUE = {CONFIG_BITS{1'b0}}
) (
    input  logic                   spi_sclk,
    input  logic                   reset,
    input  logic                   spi_cs_b,
    input  logic                   spi_sdi,
    output logic                   spi_sdo,
    output logic [CONFIG_BITS-1:0] config_out,
    output logic                   config_valid,
    output logic                   frame_err
);

    localparam int                 CNT_W    = $clog2(CONFIG_BITS + 2);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(CONFIG_BITS);
    localparam logic [CNT_W-1:0]   CNT_SAT  = CNT_W'(CONFIG_BITS + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CONFIG_BITS-1:0] shift_q,  shift_d;
    logic [CONFIG_BITS-1:0] config_q, config_d;
    logic                   valid_q,  valid_d;
    logic                   err_q,    err_d;

    always_ff @(posedge spi_sclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= RESET_VALUE;
            config_q  <= RESET_VALUE;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            config_q  <= config_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        config_d  = config_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (spi_cs_b) begin
                    // Keep the readback image in step with the committed word.
                    shift_d = config_q;
                end else begin
                    state_d   = SHIFT;
                    shift_d   = {shift_q[CONFIG_BITS-2:0], spi_sdi};
                    bit_cnt_d = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (!spi_cs_b) begin
                    shift_d = {shift_q[CONFIG_BITS-2:0], spi_sdi};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    if (bit_cnt_q == CNT_FULL) begin
                        config_d = shift_q;
                        valid_d  = 1'b1;
                        err_d    = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        shift_d = config_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_sdo      = shift_q[CONFIG_BITS-1];
    assign config_out   = config_q;
    assign config_valid = valid_q;
    assign frame_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_frida_spi_config.sv
`default_nettype none
// ============================================================================
// Module      : tb_frida_spi_config
// Description : Random-frame bench for a 16-bit and a 1280-bit instance.
// Revision    : 1.0
// ============================================================================
module tb_frida_spi_config;

    localparam int          NS = 16;
    localparam int          NB = 1280;
    localparam logic [15:0] RV_S = 16'hA5C3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs_s = 1'b1, sdi_s = 1'b0, cs_b = 1'b1, sdi_b = 1'b0;
    logic sdo_s, sdo_b, valid_s, valid_b, err_s, err_b;
    logic [NS-1:0] cfg_s;
    logic [NB-1:0] cfg_b;

    always #5 clk = ~clk;

    frida_spi_config #(.CONFIG_BITS(NS), .RESET_VALUE(RV_S)) dut_s (
        .spi_sclk(clk), .reset(rst), .spi_cs_b(cs_s), .spi_sdi(sdi_s),
        .spi_sdo(sdo_s), .config_out(cfg_s), .config_valid(valid_s), .frame_err(err_s)
    );

    frida_spi_config #(.CONFIG_BITS(NB)) dut_b (
        .spi_sclk(clk), .reset(rst), .spi_cs_b(cs_b), .spi_sdi(sdi_b),
        .spi_sdo(sdo_b), .config_out(cfg_b), .config_valid(valid_b), .frame_err(err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: committed word and sticky error flag per instance.
    logic [NB-1:0] ref_cfg [2];
    logic          ref_err [2];

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        int fd;
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            fd = -1;
            for (int k = NB - 1; k >= 0; k--) if (got[k] !== exp[k] && fd < 0) fd = k;
            $display("FAIL %s: got %h required %h (low 64 bits, first differing bit %0d)",
                     tag, got[63:0], exp[63:0], fd);
        end
    endtask

    function automatic int nbits(input bit sel);
        return sel ? NB : NS;
    endfunction

    function automatic logic [NB-1:0] get_cfg(input bit sel);
        return sel ? cfg_b : {{(NB-NS){1'b0}}, cfg_s};
    endfunction

    function automatic logic get_sdo(input bit sel);
        return sel ? sdo_b : sdo_s;
    endfunction

    function automatic logic get_valid(input bit sel);
        return sel ? valid_b : valid_s;
    endfunction

    function automatic logic get_err(input bit sel);
        return sel ? err_b : err_s;
    endfunction

    task automatic drive(input bit sel, input logic cs, input logic d);
        if (sel) begin cs_b = cs; sdi_b = d; end
        else     begin cs_s = cs; sdi_s = d; end
    endtask

    task automatic reset_model();
        ref_cfg[0] = {{(NB-NS){1'b0}}, RV_S};
        ref_cfg[1] = '0;
        ref_err[0] = 1'b0;
        ref_err[1] = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the last edge used.
    task automatic send_frame(input bit sel, input logic [NB-1:0] data, input int len, input bit trail);
        int            n;
        logic [NB-1:0] rb, mask, exp_rb, nmask;
        n      = nbits(sel);
        rb     = '0;
        mask   = '0;
        exp_rb = ref_cfg[sel];
        for (int i = 0; i < len; i++) begin
            if (i < n) begin
                rb[n-1-i]   = get_sdo(sel);
                mask[n-1-i] = 1'b1;
            end
            if (i == 1) check("valid_low_in_frame", {{(NB-1){1'b0}}, get_valid(sel)}, '0);
            drive(sel, 1'b0, data[len-1-i]);
            @(negedge clk);
        end
        check("readback", rb & mask, exp_rb & mask);
        if (trail) begin
            drive(sel, 1'b1, 1'b0);
            @(negedge clk);
            if (len == n) begin
                nmask        = sel ? {NB{1'b1}} : {{(NB-NS){1'b0}}, {NS{1'b1}}};
                ref_cfg[sel] = data & nmask;
                ref_err[sel] = 1'b0;
            end else begin
                ref_err[sel] = 1'b1;
            end
            check("config_out", get_cfg(sel), ref_cfg[sel]);
            check("config_valid", {{(NB-1){1'b0}}, get_valid(sel)}, {{(NB-1){1'b0}}, (len == n)});
            check("frame_err", {{(NB-1){1'b0}}, get_err(sel)}, {{(NB-1){1'b0}}, ref_err[sel]});
        end
    endtask

    task automatic idle(input bit sel, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(sel, 1'b1, 1'b0);
            @(negedge clk);
            if (i == 0) check("valid_pulse_end", {{(NB-1){1'b0}}, get_valid(sel)}, '0);
        end
    endtask

    task automatic check_outputs(input bit sel, input string tag);
        check({tag, "_cfg"}, get_cfg(sel), ref_cfg[sel]);
        check({tag, "_sdo"}, {{(NB-1){1'b0}}, get_sdo(sel)},
              {{(NB-1){1'b0}}, ref_cfg[sel][nbits(sel)-1]});
        check({tag, "_valid"}, {{(NB-1){1'b0}}, get_valid(sel)}, '0);
        check({tag, "_err"}, {{(NB-1){1'b0}}, get_err(sel)}, {{(NB-1){1'b0}}, ref_err[sel]});
    endtask

    initial begin
        logic [NB-1:0] d;
        int            len, r;

        reset_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs(1'b0, "reset_s");
        check_outputs(1'b1, "reset_b");

        // Directed frames on the 16-bit instance.
        send_frame(1'b0, NB'(16'h1234), 16, 1'b1);
        idle(1'b0, 1);
        send_frame(1'b0, NB'(16'h7FFF), 15, 1'b1);
        idle(1'b0, 2);
        send_frame(1'b0, NB'(17'h1ABCD), 17, 1'b1);
        idle(1'b0, 2);
        send_frame(1'b0, NB'(16'hBEEF), 16, 1'b1);
        idle(1'b0, 1);

        // Reset in the middle of a frame.
        send_frame(1'b0, NB'(8'hC6), 8, 1'b0);
        rst = 1'b1;
        #1;
        reset_model();
        check_outputs(1'b0, "midreset_s");
        check_outputs(1'b1, "midreset_b");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_outputs(1'b0, "post_reset_s");
        send_frame(1'b0, NB'(16'h00FF), 16, 1'b1);
        idle(1'b0, 1);

        // Back-to-back frames, only the commit edge between them.
        send_frame(1'b0, NB'(16'h0001), 16, 1'b1);
        send_frame(1'b0, NB'(16'h8000), 16, 1'b1);
        idle(1'b0, 1);

        // Long frame that would wrap an unsaturated counter back to 16.
        send_frame(1'b0, {$urandom(), $urandom()}, 48, 1'b1);
        idle(1'b0, 1);
        send_frame(1'b0, NB'(16'h5A5A), 16, 1'b1);
        idle(1'b0, 1);

        // Random lengths and data on the 16-bit instance.
        for (int f = 0; f < 14; f++) begin
            r   = $urandom_range(0, 3);
            len = (r == 0) ? $urandom_range(1, 15) : (r == 1) ? $urandom_range(17, 20) : 16;
            d   = NB'({$urandom(), $urandom()});
            send_frame(1'b0, d, len, 1'b1);
            idle(1'b0, $urandom_range(0, 2));
        end

        // Full-size instance: readback must equal the prior word bit-for-bit.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < NB / 32; k++) d[k*32 +: 32] = $urandom();
            send_frame(1'b1, d, NB, 1'b1);
            idle(1'b1, f);
        end
        send_frame(1'b1, d, 100, 1'b1);
        idle(1'b1, 1);
        check_outputs(1'b1, "final_b");
        check_outputs(1'b0, "final_s");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
